pipeline_stage_ctrl: RTL

Stall/flush sequencer sitting on the output side of the pipeline latches. It reads the registered IF/ID, ID/EX, EX/MEM and MEM/WB fields together with the cache hit strobes. Each cycle it decides which latches capture, which are flushed to a bubble, and whether the PC advances. It also owns the halt-drain sequence and a saturating stall-cycle counter for performance tests.

---
 rtl/pipeline_stage_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stage_ctrl.sv
// Stall/flush sequencer for the pipeline latches: decides per cycle which latches
// capture or bubble, whether the PC advances, and owns halt-drain and stall counting.
module pipeline_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             uses_rt_ID,
    input  logic [4:0]       wsel_IDEX,
    input  logic             cu_rWEN_IDEX,
    input  logic             cu_dmemREN_IDEX,
    input  logic             wdat_ready_IDEX,
    input  logic             cu_dmemREN_EXME,
    input  logic             cu_dmemWEN_EXME,
    input  logic             halt_IDEX,
    input  logic             halt_EXME,
    input  logic             halt_MEWB,
    input  logic             branch_taken_EX,
    output logic             pc_en,
    output logic             en_IFID,
    output logic             en_IDEX,
    output logic             en_EXME,
    output logic             en_MEWB,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exme;
        logic en_mewb;
        logic fl_ifid;
        logic fl_idex;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 7'b000_0000;
    localparam ctrl_t CTRL_BRANCH = 7'b111_1111;
    localparam ctrl_t CTRL_BUBBLE = 7'b001_1101;
    localparam ctrl_t CTRL_DRAIN  = 7'b011_1110;
    localparam ctrl_t CTRL_GO     = 7'b111_1100;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            next_state_s;
    logic              halted_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    ctrl_t             flow_s;
    ctrl_t             ctrl_s;
    logic              memop_s;
    logic              loaduse_s;
    logic              drain_s;
    logic              rs_match_s;
    logic              rt_match_s;

    assign memop_s    = cu_dmemREN_EXME | cu_dmemWEN_EXME;
    assign rs_match_s = (wsel_IDEX == rs_ID);
    assign rt_match_s = uses_rt_ID & (wsel_IDEX == rt_ID);
    assign loaduse_s  = cu_dmemREN_IDEX & cu_rWEN_IDEX & ~wdat_ready_IDEX
                      & (wsel_IDEX != 5'd0) & (rs_match_s | rt_match_s);
    assign drain_s    = halt_IDEX | halt_EXME;

    // Free-flowing decision once no memory freeze applies (shared by RUN and DWAIT exit)
    always_comb begin
        flow_s = CTRL_GO;
        if (branch_taken_EX) begin
            flow_s = CTRL_BRANCH;
        end else if (loaduse_s) begin
            flow_s = CTRL_BUBBLE;
        end else if (drain_s | ~ihit) begin
            flow_s = CTRL_DRAIN;
        end else begin
            flow_s = CTRL_GO;
        end
    end

    // Next-state and Mealy control selection
    always_comb begin
        next_state_s = state_r;
        ctrl_s       = CTRL_FREEZE;
        case (state_r)
            RUN: begin
                if (halt_MEWB) begin
                    next_state_s = HALT;
                    ctrl_s       = CTRL_FREEZE;
                end else if (memop_s & ~dhit) begin
                    next_state_s = DWAIT;
                    ctrl_s       = CTRL_FREEZE;
                end else begin
                    next_state_s = RUN;
                    ctrl_s       = flow_s;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    next_state_s = RUN;
                    ctrl_s       = flow_s;
                end else begin
                    next_state_s = DWAIT;
                    ctrl_s       = CTRL_FREEZE;
                end
            end
            HALT: begin
                next_state_s = HALT;
                ctrl_s       = CTRL_FREEZE;
            end
            default: begin
                next_state_s = RUN;
                ctrl_s       = CTRL_FREEZE;
            end
        endcase
    end

    // State and halted flag registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == HALT);
        end
    end

    // Saturating count of stalled (PC held) cycles outside HALT
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!ctrl_s.pc_en && (state_r != HALT) && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Reset forces every control low immediately; a flush only matters with its enable
    assign pc_en      = nRST & ctrl_s.pc_en;
    assign en_IFID    = nRST & ctrl_s.en_ifid;
    assign en_IDEX    = nRST & ctrl_s.en_idex;
    assign en_EXME    = nRST & ctrl_s.en_exme;
    assign en_MEWB    = nRST & ctrl_s.en_mewb;
    assign flush_IFID = nRST & ctrl_s.en_ifid & ctrl_s.fl_ifid;
    assign flush_IDEX = nRST & ctrl_s.en_idex & ctrl_s.fl_idex;
    assign halted     = halted_r;
    assign stall_cnt  = stall_cnt_r;
    assign state      = state_r;

endmodule
